enc_16to4_drain: RTL and testbench

//  Sequential priority encoder: the reverse direction of the team's 16-line decoder path.

---
 rtl/enc_pkg.sv | 20 ++
 rtl/enc_16to4_drain_if.sv | 30 +++
 rtl/pri_enc_16to4.sv | 36 +++
 rtl/enc_16to4_drain.sv | 94 +++++++++
 tb/tb_enc_16to4_drain.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/enc_pkg.sv
// Shared definitions for the sequential priority encoder: FSM state encoding
// and the code-width helper used to size ports from the line count.
package enc_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    localparam int N_DEF = 16;
    localparam int W_DEF = clog2(N_DEF);

endpackage

// File: rtl/enc_16to4_drain_if.sv
// Request-vector and code handshakes between request sources, the encoder and
// the code consumer.
interface enc_16to4_drain_if #(
    parameter int N = 16
);
    import enc_pkg::*;

    localparam int W = clog2(N);

    // Both channels use valid/ready: a beat transfers on a rising clock edge
    // where valid && ready; the sender holds payload stable while valid && !ready.
    logic         req_valid;
    logic [N-1:0] req;
    logic         req_ready;
    logic         code_valid;
    logic [W-1:0] code;
    logic         code_last;
    logic         code_ready;

    modport master (
        output req_valid, req, code_ready,
        input  req_ready, code_valid, code, code_last
    );

    modport slave (
        input  req_valid, req, code_ready,
        output req_ready, code_valid, code, code_last
    );

endinterface

// File: rtl/pri_enc_16to4.sv
// Combinational priority encoder: index of the winning set line, plus
// any-set and exactly-one-set flags.
module pri_enc_16to4
    import enc_pkg::*;
#(
    parameter int N         = 16,
    parameter bit LSB_FIRST = 1'b1,
    localparam int W        = clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any,
    output logic         onehot
);

    logic [N-1:0] vec_m1;

    // Scan away from the priority end so the last hit is the winner.
    always_comb begin
        idx = '0;
        if (LSB_FIRST) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (vec[i]) idx = i[W-1:0];
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (vec[i]) idx = i[W-1:0];
            end
        end
    end

    assign any    = |vec;
    assign vec_m1 = vec - {{(N-1){1'b0}}, 1'b1};
    assign onehot = any && ((vec & vec_m1) == '0);

endmodule

// File: rtl/enc_16to4_drain.sv
// Sequential priority encoder: captures a request vector, then issues the index
// of each set line, one per accepted code, in priority order.
module enc_16to4_drain
    import enc_pkg::*;
#(
    parameter int N         = 16,
    parameter bit LSB_FIRST = 1'b1,
    localparam int W        = clog2(N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    enc_16to4_drain_if.slave    bus,
    output logic [W:0]          count,
    output logic                zero_seen,
    output state_t              dbg_state
);

    state_t       state, state_nxt;
    logic [N-1:0] pending, pending_nxt, clr_mask;
    logic [W:0]   req_pop;
    logic [W-1:0] pri_idx;
    logic         pri_any, pri_onehot;
    logic         capture, accept;

    pri_enc_16to4 #(
        .N         (N),
        .LSB_FIRST (LSB_FIRST)
    ) u_pri (
        .vec    (pending),
        .idx    (pri_idx),
        .any    (pri_any),
        .onehot (pri_onehot)
    );

    always_comb begin
        req_pop = '0;
        for (int i = 0; i < N; i++) begin
            req_pop = req_pop + {{W{1'b0}}, bus.req[i]};
        end
    end

    always_comb begin
        state_nxt      = state;
        pending_nxt    = pending;
        bus.req_ready  = 1'b0;
        bus.code_valid = 1'b0;
        bus.code       = '0;
        bus.code_last  = 1'b0;
        capture        = 1'b0;
        accept         = 1'b0;
        clr_mask       = '0;
        clr_mask[pri_idx] = 1'b1;
        case (state)
            ST_IDLE: begin
                bus.req_ready = en && !rst;
                capture       = bus.req_valid && en && !rst;
                if (capture) begin
                    pending_nxt = bus.req;
                    if (bus.req != '0) state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                bus.code_valid = pri_any;
                bus.code       = pri_idx;
                bus.code_last  = pri_onehot;
                accept         = bus.code_ready && pri_any;
                if (accept) begin
                    pending_nxt = pending & ~clr_mask;
                    if (pri_onehot) state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // en gates capture only; an in-progress drain always runs to completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            pending   <= '0;
            count     <= '0;
            zero_seen <= 1'b0;
        end else begin
            state     <= state_nxt;
            pending   <= pending_nxt;
            zero_seen <= capture && (bus.req == '0);
            if (capture) count <= req_pop;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_enc_16to4_drain.sv
// Bench for enc_16to4_drain: an LSB-first and an MSB-first instance share the
// same stimulus and are checked against hand-computed code sequences.
module tb_enc_16to4_drain;
    import enc_pkg::*;

    typedef struct {
        logic [15:0] req;
        int          cnt;
        logic [63:0] lsb_codes;   // nibble k = k-th code, LSB-first instance
        logic [63:0] msb_codes;   // nibble k = k-th code, MSB-first instance
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        req_valid = 1'b0;
    logic        code_ready = 1'b0;
    logic [15:0] req = '0;
    logic [4:0]  count_a, count_b;
    logic        zero_a, zero_b;
    state_t      st_a, st_b;

    int n_pass = 0;
    int n_total = 0;
    vec_t vecs[7];

    enc_16to4_drain_if #(.N(16)) if_a ();
    enc_16to4_drain_if #(.N(16)) if_b ();

    assign if_a.req_valid  = req_valid;
    assign if_a.req        = req;
    assign if_a.code_ready = code_ready;
    assign if_b.req_valid  = req_valid;
    assign if_b.req        = req;
    assign if_b.code_ready = code_ready;

    enc_16to4_drain #(.N(16), .LSB_FIRST(1'b1)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .bus       (if_a.slave),
        .count     (count_a),
        .zero_seen (zero_a),
        .dbg_state (st_a)
    );

    enc_16to4_drain #(.N(16), .LSB_FIRST(1'b0)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .bus       (if_b.slave),
        .count     (count_b),
        .zero_seen (zero_b),
        .dbg_state (st_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_codes(input string tag, input logic [3:0] ca, input logic la,
                             input logic [3:0] cb, input logic lb);
        chk({tag, "_valid_a"}, if_a.code_valid, 1);
        chk({tag, "_valid_b"}, if_b.code_valid, 1);
        chk({tag, "_code_a"}, if_a.code, ca);
        chk({tag, "_code_b"}, if_b.code, cb);
        chk({tag, "_last_a"}, if_a.code_last, la);
        chk({tag, "_last_b"}, if_b.code_last, lb);
    endtask

    task automatic chk_idle(input string tag, input logic rdy);
        chk({tag, "_valid_a"}, if_a.code_valid, 0);
        chk({tag, "_valid_b"}, if_b.code_valid, 0);
        chk({tag, "_ready_a"}, if_a.req_ready, rdy);
        chk({tag, "_ready_b"}, if_b.req_ready, rdy);
        chk({tag, "_state_a"}, st_a, ST_IDLE);
        chk({tag, "_state_b"}, st_b, ST_IDLE);
    endtask

    initial begin
        logic [63:0] lc, mc;
        vecs[0] = '{16'h8421, 4, 64'hFA50, 64'h05AF};
        vecs[1] = '{16'h0001, 1, 64'h0, 64'h0};
        vecs[2] = '{16'h8000, 1, 64'hF, 64'hF};
        vecs[3] = '{16'h0030, 2, 64'h54, 64'h45};
        vecs[4] = '{16'hFFFF, 16, 64'hFEDCBA9876543210, 64'h0123456789ABCDEF};
        vecs[5] = '{16'h1234, 5, 64'hC9542, 64'h2459C};
        vecs[6] = '{16'hA000, 2, 64'hFD, 64'hDF};

        // Reset state
        step();
        step();
        chk("rst_valid_a", if_a.code_valid, 0);
        chk("rst_code_a", if_a.code, 0);
        chk("rst_last_a", if_a.code_last, 0);
        chk("rst_count_a", count_a, 0);
        chk("rst_zero_a", zero_a, 0);
        en = 1'b1;
        #1;
        chk("rst_ready_a", if_a.req_ready, 0);
        chk("rst_ready_b", if_b.req_ready, 0);
        rst = 1'b0;
        step();
        chk_idle("post_rst", 1);

        // Table-driven drains with code_ready held high
        for (int v = 0; v < 7; v++) begin
            lc = vecs[v].lsb_codes;
            mc = vecs[v].msb_codes;
            req = vecs[v].req;
            req_valid = 1'b1;
            en = 1'b1;
            code_ready = 1'b1;
            chk("tbl_ready", if_a.req_ready, 1);
            step();
            req_valid = 1'b0;
            req = 16'h5A5A;
            chk("tbl_count_a", count_a, 64'(vecs[v].cnt));
            chk("tbl_count_b", count_b, 64'(vecs[v].cnt));
            for (int k = 0; k < vecs[v].cnt; k++) begin
                chk_codes("tbl", lc[4*k +: 4], (k == vecs[v].cnt - 1),
                          mc[4*k +: 4], (k == vecs[v].cnt - 1));
                chk("tbl_busy_ready", if_a.req_ready, 0);
                step();
            end
            chk_idle("tbl_done", 1);
            chk("tbl_count_held", count_a, 64'(vecs[v].cnt));
        end

        // Backpressure: code held stable while code_ready is low
        req = 16'h0030;
        req_valid = 1'b1;
        code_ready = 1'b0;
        step();
        req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk_codes("bp_hold", 4'd4, 1'b0, 4'd5, 1'b0);
            step();
        end
        code_ready = 1'b1;
        chk_codes("bp_first", 4'd4, 1'b0, 4'd5, 1'b0);
        step();
        chk_codes("bp_second", 4'd5, 1'b1, 4'd4, 1'b1);
        step();
        chk_idle("bp_done", 1);

        // All-zero capture: one-cycle zero_seen, no codes
        req = 16'h0000;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        chk("zero_pulse_a", zero_a, 1);
        chk("zero_pulse_b", zero_b, 1);
        chk("zero_count_a", count_a, 0);
        chk_idle("zero_cap", 1);
        step();
        chk("zero_drop_a", zero_a, 0);
        chk("zero_drop_b", zero_b, 0);
        chk_idle("zero_after", 1);

        // Reset in the middle of a drain
        req = 16'hFFFF;
        req_valid = 1'b1;
        code_ready = 1'b1;
        step();
        req_valid = 1'b0;
        chk_codes("mid_c0", 4'd0, 1'b0, 4'd15, 1'b0);
        step();
        chk_codes("mid_c1", 4'd1, 1'b0, 4'd14, 1'b0);
        step();
        rst = 1'b1;
        #1;
        chk("mid_rst_valid_a", if_a.code_valid, 0);
        chk("mid_rst_valid_b", if_b.code_valid, 0);
        chk("mid_rst_code_a", if_a.code, 0);
        chk("mid_rst_count_a", count_a, 0);
        chk("mid_rst_ready_a", if_a.req_ready, 0);
        step();
        rst = 1'b0;
        #1;
        chk_idle("mid_rel", 1);
        step();
        chk_idle("mid_rel2", 1);

        // en low blocks capture; raising en captures that cycle
        en = 1'b0;
        req = 16'h8421;
        req_valid = 1'b1;
        #1;
        chk("en_lo_ready", if_a.req_ready, 0);
        step();
        chk_idle("en_lo_hold", 0);
        en = 1'b1;
        #1;
        chk("en_hi_ready", if_a.req_ready, 1);
        step();
        req_valid = 1'b0;
        en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            lc = 64'hFA50;
            mc = 64'h05AF;
            chk_codes("en_drain", lc[4*k +: 4], (k == 3), mc[4*k +: 4], (k == 3));
            step();
        end
        chk_idle("en_drain_done", 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
